// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: fetch-stage defaults and the IF/ID latch bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  // Contents of the IF/ID pipeline latch
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        adel;
  } if_id_t;

  // An empty slot: every field zero, so ID sees a NOP with nothing flagged
  localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR,
                                      valid: 1'b0, adel: 1'b0};

endpackage : cpu_pkg

// File: rtl/pc_adder.sv
// Sequential-PC incrementer: pc + 4, wrapping modulo 2^32.
// Latency: combinational.
// Backpressure: none.
module pc_adder (
  input  logic [31:0] pc,
  output logic [31:0] pc4
);

  assign pc4 = pc + 32'd4;

endmodule : pc_adder

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, picks the next PC, and fills the IF/ID latch.
// Latency: instruction at imem_addr = A appears in IF/ID one cycle later.
// Backpressure: stall_if holds PC and IF/ID; a redirect seen during a stall is parked until the stall lifts.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_if,
  input  logic        flush_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_valid,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        if_id_adel
);

  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  if_id_t      if_id_q, if_id_d;

  logic [31:0] pc4;
  logic        adel_now;
  logic        redirect_applied;

  pc_adder u_pc_adder (
    .pc  (pc_q),
    .pc4 (pc4)
  );

  // Low address bits nonzero means a misaligned fetch; flagged downstream, not trapped here
  assign adel_now = (pc_q[1:0] != 2'b00);

  // Next-PC selection and pending-redirect bookkeeping (exception > redirect > pending > stall > sequential)
  always_comb begin
    pc_d             = pc4;
    pend_valid_d     = pend_valid_q;
    pend_target_d    = pend_target_q;
    redirect_applied = 1'b0;
    if (exc_valid) begin
      pc_d         = EXC_VECTOR;
      pend_valid_d = 1'b0;
    end else if (redirect_valid && !stall_if) begin
      // A fresh redirect supersedes anything still parked
      pc_d             = redirect_target;
      pend_valid_d     = 1'b0;
      redirect_applied = 1'b1;
    end else if (pend_valid_q && !stall_if) begin
      pc_d             = pend_target_q;
      pend_valid_d     = 1'b0;
      redirect_applied = 1'b1;
    end else if (stall_if) begin
      pc_d = pc_q;
      if (redirect_valid) begin
        // Park the target; a later redirect in the same stall overwrites it
        pend_valid_d  = 1'b1;
        pend_target_d = redirect_target;
      end
    end
  end

  // IF/ID latch contents: bubble on exception/flush/taken redirect, hold on stall, else capture fetch
  always_comb begin
    if_id_d = if_id_q;
    if (exc_valid || flush_id) begin
      if_id_d = IF_ID_BUBBLE;
    end else if (stall_if) begin
      if_id_d = if_id_q;
    end else if (redirect_applied) begin
      // Wrong-path instruction is squashed; there is no delay slot
      if_id_d = IF_ID_BUBBLE;
    end else begin
      if_id_d.pc    = pc_q;
      if_id_d.pc4   = pc4;
      if_id_d.instr = adel_now ? NOP_INSTR : imem_rdata;
      if_id_d.valid = 1'b1;
      if_id_d.adel  = adel_now;
    end
  end

  // State registers with synchronous reset that discards any pending redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      if_id_q       <= IF_ID_BUBBLE;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      if_id_q       <= if_id_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;
  assign if_id_adel  = if_id_q.adel;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, redirects, stall parking, exception, wrap, misalignment.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall_if driven directly by the bench.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_if;
  logic        flush_id;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        if_id_adel;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [31:0] MEM_XOR = 32'hA5A5_0000;

  // Instruction memory model: word content derived from its address
  assign imem_rdata = imem_addr ^ MEM_XOR;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall_if        (stall_if),
    .flush_id        (flush_id),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_valid       (exc_valid),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .if_id_pc        (if_id_pc),
    .if_id_pc4       (if_id_pc4),
    .if_id_instr     (if_id_instr),
    .if_id_valid     (if_id_valid),
    .if_id_adel      (if_id_adel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall_if = 1'b0; flush_id = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0; exc_valid = 1'b0;

    // Reset for two cycles
    tick(); tick();
    chk("rst_addr",   imem_addr, 32'h0000_3000);
    chk("rst_valid",  {31'h0, if_id_valid}, 32'h0);
    chk("rst_pc",     if_id_pc, 32'h0);
    chk("rst_instr",  if_id_instr, 32'h0);
    chk("rst_pend",   {31'h0, dut.pend_valid_q}, 32'h0);
    chk("rst_ptgt",   dut.pend_target_q, 32'h0);

    // Sequential fetch
    reset = 1'b0;
    tick();
    chk("seq1_addr",  imem_addr, 32'h0000_3004);
    chk("seq1_pc",    if_id_pc, 32'h0000_3000);
    chk("seq1_pc4",   if_id_pc4, 32'h0000_3004);
    chk("seq1_instr", if_id_instr, 32'hA5A5_3000);
    chk("seq1_valid", {31'h0, if_id_valid}, 32'h1);
    chk("seq1_adel",  {31'h0, if_id_adel}, 32'h0);
    tick();
    chk("seq2_addr",  imem_addr, 32'h0000_3008);
    chk("seq2_pc",    if_id_pc, 32'h0000_3004);

    // Unstalled redirect at pc 3008
    redirect_valid = 1'b1; redirect_target = 32'h0000_3100;
    tick();
    chk("rd_addr",    imem_addr, 32'h0000_3100);
    chk("rd_bubble",  {31'h0, if_id_valid}, 32'h0);
    chk("rd_bpc",     if_id_pc, 32'h0);
    redirect_valid = 1'b0;
    tick();
    chk("rd2_addr",   imem_addr, 32'h0000_3104);
    chk("rd2_pc",     if_id_pc, 32'h0000_3100);
    chk("rd2_instr",  if_id_instr, 32'hA5A5_3100);
    chk("rd2_valid",  {31'h0, if_id_valid}, 32'h1);

    // Redirect in the first of three stalled cycles
    stall_if = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_3200;
    tick();
    chk("st1_addr",   imem_addr, 32'h0000_3104);
    chk("st1_pend",   {31'h0, dut.pend_valid_q}, 32'h1);
    chk("st1_hold",   if_id_pc, 32'h0000_3100);
    redirect_valid = 1'b0;
    tick();
    chk("st2_addr",   imem_addr, 32'h0000_3104);
    tick();
    chk("st3_addr",   imem_addr, 32'h0000_3104);
    chk("st3_ptgt",   dut.pend_target_q, 32'h0000_3200);
    stall_if = 1'b0;
    tick();
    chk("stx_addr",   imem_addr, 32'h0000_3200);
    chk("stx_bubble", {31'h0, if_id_valid}, 32'h0);
    chk("stx_pend",   {31'h0, dut.pend_valid_q}, 32'h0);
    tick();
    chk("sty_addr",   imem_addr, 32'h0000_3204);
    chk("sty_pc",     if_id_pc, 32'h0000_3200);
    chk("sty_valid",  {31'h0, if_id_valid}, 32'h1);

    // Exception beats stall, flush and redirect; also clears a just-parked redirect
    stall_if = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_3300;
    tick();
    chk("ex0_pend",   {31'h0, dut.pend_valid_q}, 32'h1);
    flush_id = 1'b1; exc_valid = 1'b1;
    tick();
    chk("exc_addr",   imem_addr, 32'h0000_4180);
    chk("exc_bubble", {31'h0, if_id_valid}, 32'h0);
    chk("exc_pend",   {31'h0, dut.pend_valid_q}, 32'h0);
    stall_if = 1'b0; flush_id = 1'b0; redirect_valid = 1'b0; exc_valid = 1'b0;
    tick();
    chk("exc2_addr",  imem_addr, 32'h0000_4184);
    chk("exc2_pc",    if_id_pc, 32'h0000_4180);

    // Wrap-around of the sequential PC
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    chk("wr_addr",    imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick();
    chk("wr2_addr",   imem_addr, 32'h0000_0000);
    chk("wr2_pc",     if_id_pc, 32'hFFFF_FFFC);
    chk("wr2_pc4",    if_id_pc4, 32'h0000_0000);

    // Misaligned fetch flagged with a NOP
    redirect_valid = 1'b1; redirect_target = 32'h0000_3002;
    tick();
    chk("ma_addr",    imem_addr, 32'h0000_3002);
    redirect_valid = 1'b0;
    tick();
    chk("ma_pc",      if_id_pc, 32'h0000_3002);
    chk("ma_pc4",     if_id_pc4, 32'h0000_3006);
    chk("ma_valid",   {31'h0, if_id_valid}, 32'h1);
    chk("ma_adel",    {31'h0, if_id_adel}, 32'h1);
    chk("ma_instr",   if_id_instr, 32'h0);

    // Reset while stalled with a pending redirect
    stall_if = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_5000;
    tick();
    chk("rm_pend",    {31'h0, dut.pend_valid_q}, 32'h1);
    redirect_valid = 1'b0; reset = 1'b1;
    tick();
    chk("rm_addr",    imem_addr, 32'h0000_3000);
    chk("rm_pend0",   {31'h0, dut.pend_valid_q}, 32'h0);
    chk("rm_bubble",  {31'h0, if_id_valid}, 32'h0);
    reset = 1'b0; stall_if = 1'b0;
    tick();
    chk("rm2_addr",   imem_addr, 32'h0000_3004);
    chk("rm2_pc",     if_id_pc, 32'h0000_3000);
    chk("rm2_valid",  {31'h0, if_id_valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipeline: it holds the program counter, drives the instruction-memory address, selects the next PC (sequential, branch/jump redirect, exception vector), and registers the fetched instruction into the IF/ID pipeline latch. It consumes the PC+4 incrementer and feeds the ID stage. Stall and flush come from the hazard unit. Redirects come from branch/jump resolution; exceptions come from CP0.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset
- EXC_VECTOR, 32'h0000_4180, PC loaded on exception

Ports:
- clk, in, 1, sole clock; all state updates on rising edge
- reset, in, 1, synchronous, active-high
- stall_if, in, 1, hold PC and IF/ID latch this cycle
- flush_id, in, 1, load a bubble into IF/ID this cycle
- redirect_valid, in, 1, branch/jump taken this cycle
- redirect_target, in, 32, taken-branch/jump target
- exc_valid, in, 1, exception/eret redirect to EXC_VECTOR
- imem_addr, out, 32, instruction-memory address (= PC)
- imem_rdata, in, 32, instruction word, combinational read of imem_addr
- if_id_pc, out, 32, PC of instruction in IF/ID
- if_id_pc4, out, 32, that PC + 4
- if_id_instr, out, 32, instruction word in IF/ID
- if_id_valid, out, 1, IF/ID holds a real instruction
- if_id_adel, out, 1, fetch address misaligned

## Operation
- State:
  - pc[31:0]
  - pend_valid
  - pend_target[31:0]
  - IF/ID latch: pc, pc4, instr, valid, adel
- pc4 = pc + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0.
- Next-PC priority, highest first:
  1. reset → RESET_PC.
  2. exc_valid → EXC_VECTOR. Ignores stall_if and clears pend_valid.
  3. redirect_valid && !stall_if → redirect_target.
  4. pend_valid && !stall_if → pend_target, and clear pend_valid.
  5. stall_if → hold pc.
  6. Otherwise → pc4.
- Redirect during stall:
  - redirect_valid && stall_if → capture pend_target = redirect_target, set pend_valid; pc holds.
  - A later redirect while pending overwrites pend_target.
- IF/ID update:
  - Bubble = valid=0, instr=0, pc=0, pc4=0, adel=0.
  - Loads a bubble if reset, exc_valid, or flush_id. flush_id loads the bubble even when stall_if is high.
  - Otherwise, if stall_if: hold all fields.
  - Otherwise, if a redirect or pending redirect is applied this cycle: bubble (wrong-path squash; no delay slot).
  - Otherwise: {pc, pc4, imem_rdata, 1, adel_now}.
- Misalignment: adel_now = (pc[1:0] != 0). In that case IF/ID gets instr=0 (NOP), valid=1, adel=1. Misalignment is flagged, not trapped, here.
- No combinational path from any input to any output except imem_rdata → nothing (imem_addr depends on pc only).

## Timing
- Reset values:
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - IF/ID = bubble.
  - pend_valid = 0, pend_target = 0.
- Reset asserted mid-stall or with pending redirect discards everything; first fetch after release is at RESET_PC.
- Sequential fetch: one instruction per cycle. Instruction at address A appears in IF/ID one cycle after imem_addr = A.
- Redirect at cycle t (unstalled):
  - pc = target at t+1.
  - IF/ID = bubble at t+1.
  - Target instruction in IF/ID at t+2.
- Redirect at t with stall_if high through t+k:
  - pc holds through t+k.
  - pc = target at t+k+2, i.e. the first unstalled edge applies the pending target.
  - The redirect and stall are simultaneous with the squash: the wrong-path instruction never gets valid=1 after the redirect.
- exc_valid at t: pc = EXC_VECTOR and IF/ID bubble at t+1, regardless of stall_if, flush_id, or redirect.

## Structure
- Shared package (cpu_pkg):
  - RESET_PC / EXC_VECTOR defaults
  - NOP_INSTR = 32'h0
  - IF/ID bundle typedef {pc, pc4, instr, valid, adel}
- One sub-module: pc_adder (32-bit +4 incrementer), instantiated once for pc4.
- Next-PC mux, pending-redirect register and IF/ID latch live in fetch_unit.

## Test plan
- **Reset and sequential fetch.** Reset for 2 cycles, then release with imem returning addr-derived words.
  - Required: imem_addr = 3000, 3004, 3008; IF/ID shows pc 3000, pc4 3004, valid=1 one cycle later.
- **Unstalled redirect.** redirect_valid with target 32'h0000_3100 at pc 3008.
  - Required: next imem_addr = 3100; IF/ID bubble (valid=0); then IF/ID pc = 3100.
- **Redirect while stalled.** Hold stall_if 3 cycles; pulse redirect to 32'h3200 in the first cycle.
  - Required: pc holds during stall; first unstalled edge → pc = 3200; no valid wrong-path instruction.
- **Exception priority.** exc_valid together with stall_if, flush_id and redirect_valid.
  - Required: pc = 4180 next cycle, IF/ID bubble, pend_valid cleared.
- **Wrap and misalignment.**
  - Redirect to 32'hFFFF_FFFC → following pc = 0.
  - Redirect to 32'h3002 → IF/ID valid=1, adel=1, instr=0.
- **Reset mid-operation.** Reset during a pending redirect.
  - Required: pc = RESET_PC, pend_valid=0, IF/ID bubble.
